sbox_ctr_stream_cipher: RTL and testbench

Parametrised multi-lane successor of the single-byte AES S-box stream cipher. Each accepted beat carries `LANES` bytes, and each byte is XORed with a keystream byte `SBOX[(key + n) mod 256]`, where `n` is the byte's position in the message since the last key load. The block sits between a byte-stream source and sink and uses valid/ready handshakes on both sides, so it handles backpressure. Encryption and decryption are the same operation.

---
 rtl/sbox_ctr_stream_cipher_if.sv | 55 +++++
 rtl/sbox_ctr_stream_cipher.sv | 137 +++++++++++++
 tb/tb_sbox_ctr_stream_cipher.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sbox_ctr_stream_cipher_if.sv
// -----------------------------------------------------------------------------
// sbox_ctr_stream_cipher_if
// Bundles the key strobe, the input byte stream, the output byte stream and
// the busy flag of the S-box counter-mode stream cipher.
//
// Handshake semantics (both streams): a beat transfers in a cycle where
// valid && ready are both high at the rising clock edge. A source holds its
// valid high and its payload stable until the transfer. A sink may raise or
// lower ready at any time. in_ready is produced combinationally from
// state, key_load and out_ready; out_* is registered.
//
// Signals:
//   key_load   1        start a new message, load key
//   key        8        initial keystream index
//   in_valid   1        input beat valid
//   in_ready   1        input beat accepted
//   in_data    8*LANES  input bytes, lane i at [8i+7:8i]
//   in_keep    LANES    byte enables, contiguous from lane 0
//   in_last    1        final beat of the message
//   out_valid  1        output beat valid
//   out_ready  1        sink accepts the output beat
//   out_data   8*LANES  XORed bytes, unkept lanes are zero
//   out_keep   LANES    keep of the beat
//   out_last   1        last flag of the beat
//   busy       1        message open
// Modports: master (source/sink side, drives the inputs of the cipher),
//           slave (the cipher).
// -----------------------------------------------------------------------------
interface sbox_ctr_stream_cipher_if #(
    parameter int LANES = 4
);
    logic                 key_load;
    logic [7:0]           key;
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic [LANES-1:0]     in_keep;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic [LANES-1:0]     out_keep;
    logic                 out_last;
    logic                 busy;

    modport master (
        output key_load, key, in_valid, in_data, in_keep, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, busy
    );

    modport slave (
        input  key_load, key, in_valid, in_data, in_keep, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, busy
    );
endinterface

// File: rtl/sbox_ctr_stream_cipher.sv
// -----------------------------------------------------------------------------
// sbox_ctr_stream_cipher
// Multi-lane stream cipher: every kept byte of an accepted beat is XORed with
// AES_SBOX[(ctr + lane) mod 256], where ctr counts bytes since the last key
// load. Encryption and decryption are the same operation. One register stage
// between input and output, full throughput under continuous out_ready.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   bus          sbox_ctr_stream_cipher_if.slave (key, in/out streams, busy)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = RUN)
//   dbg_ctr_o    current keystream counter
// -----------------------------------------------------------------------------
module sbox_ctr_stream_cipher #(
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sbox_ctr_stream_cipher_if.slave      bus,
    output logic [0:0]                   dbg_state_o,
    output logic [7:0]                   dbg_ctr_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_e               state_q, state_d;
    logic [7:0]           ctr_q, ctr_d;
    logic                 out_valid_q, out_valid_d;
    logic [8*LANES-1:0]   out_data_q, out_data_d;
    logic [LANES-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;

    logic                 in_ready;
    logic                 accept;
    logic [7:0]           keep_count;
    logic [8*LANES-1:0]   xored_data;

    // key_load wins over beat acceptance; the output register must be free
    // or draining this cycle before a new beat may enter.
    assign in_ready = (state_q == RUN) && !bus.key_load && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Keystream lanes: the lane index is added in 8 bits so lanes that
    // straddle 0xFF wrap to 0x00.
    always_comb begin
        keep_count = '0;
        xored_data = '0;
        for (int i = 0; i < LANES; i++) begin
            keep_count = keep_count + {7'd0, bus.in_keep[i]};
            if (bus.in_keep[i]) begin
                xored_data[8*i +: 8] = bus.in_data[8*i +: 8] ^ SBOX[8'(ctr_q + 8'(i))];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        if (bus.key_load) begin
            state_d = RUN;
            ctr_d   = bus.key;
        end else if (accept) begin
            ctr_d = ctr_q + keep_count;
            if (bus.in_last) begin
                state_d = IDLE;
            end
        end

        // Output register: load on acceptance, otherwise release when taken.
        // A pending beat is untouched by key_load.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = xored_data;
            out_keep_d  = bus.in_keep;
            out_last_d  = bus.in_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctr_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == RUN);

    assign dbg_state_o = state_q;
    assign dbg_ctr_o   = ctr_q;

endmodule

// File: tb/tb_sbox_ctr_stream_cipher.sv
// -----------------------------------------------------------------------------
// tb_sbox_ctr_stream_cipher
// Directed bench for sbox_ctr_stream_cipher with LANES = 4. Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 time unit after the
// edge (or after the combinational input change), away from the clock edge.
// -----------------------------------------------------------------------------
module tb_sbox_ctr_stream_cipher;

    localparam int LANES = 4;

    logic       clk;
    logic       rst_n;
    logic [0:0] dbg_state;
    logic [7:0] dbg_ctr;

    int checks   = 0;
    int failures = 0;

    sbox_ctr_stream_cipher_if #(.LANES(LANES)) bus ();

    sbox_ctr_stream_cipher #(.LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state),
        .dbg_ctr_o   (dbg_ctr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input logic valid, input logic [31:0] data,
                              input logic [3:0] keep, input logic last);
        bus.in_valid = valid;
        bus.in_data  = data;
        bus.in_keep  = keep;
        bus.in_last  = last;
    endtask

    task automatic load_key(input logic [7:0] k);
        bus.key_load = 1'b1;
        bus.key      = k;
        tick();
        bus.key_load = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.key_load  = 1'b0;
        bus.key       = 8'h00;
        bus.out_ready = 1'b1;
        drive_beat(1'b0, 32'h0, 4'h0, 1'b0);
        #12;

        // reset state
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data",  bus.out_data, 32'h0);
        check("rst_out_keep",  {28'd0, bus.out_keep}, 32'd0);
        check("rst_out_last",  {31'd0, bus.out_last}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        check("rst_ctr",       {24'd0, dbg_ctr}, 32'd0);
        rst_n = 1'b1;

        // no acceptance before a key load
        drive_beat(1'b1, 32'h0, 4'hF, 1'b0);
        tick();
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("idle_no_out", {31'd0, bus.out_valid}, 32'd0);

        // basic stream, key 0x00
        bus.key_load = 1'b1;
        bus.key      = 8'h00;
        #1;
        check("kl_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.key_load = 1'b0;
        #1;
        check("run_busy", {31'd0, bus.busy}, 32'd1);
        check("run_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("basic_b1_valid", {31'd0, bus.out_valid}, 32'd1);
        check("basic_b1_data", bus.out_data, 32'h7B777C63);
        check("basic_b1_ctr", {24'd0, dbg_ctr}, 32'h04);
        tick();
        check("basic_b2_data", bus.out_data, 32'hC56F6BF2);
        check("basic_ctr", {24'd0, dbg_ctr}, 32'h08);
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        tick();
        check("basic_drained", {31'd0, bus.out_valid}, 32'd0);

        // wrap of the keystream index
        load_key(8'hFE);
        drive_beat(1'b1, 32'h0, 4'hF, 1'b0);
        tick();
        check("wrap_data", bus.out_data, 32'h7C6316BB);
        check("wrap_ctr", {24'd0, dbg_ctr}, 32'h02);
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        tick();

        // backpressure, message continues at ctr = 0x02
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h11223344, 4'hF, 1'b0);
        tick();
        check("bp_first_data", bus.out_data, 32'h7AD04833);
        drive_beat(1'b1, 32'h00000000, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_data", bus.out_data, 32'h7AD04833);
            check("bp_hold_keep", {28'd0, bus.out_keep}, 32'hF);
            check("bp_hold_last", {31'd0, bus.out_last}, 32'd0);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_ctr", {24'd0, dbg_ctr}, 32'h06);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check("bp_next_data", bus.out_data, 32'h0130C56F);
        check("bp_next_ctr", {24'd0, dbg_ctr}, 32'h0A);
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        tick();
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // mid-message key load with a beat pending
        load_key(8'h00);
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h11223344, 4'hF, 1'b0);
        tick();
        check("mk_cipher", bus.out_data, 32'h6A554F27);
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        bus.key_load = 1'b1;
        bus.key      = 8'h00;
        tick();
        bus.key_load = 1'b0;
        check("mk_pending_valid", {31'd0, bus.out_valid}, 32'd1);
        check("mk_pending_data", bus.out_data, 32'h6A554F27);
        check("mk_ctr_reload", {24'd0, dbg_ctr}, 32'h00);
        bus.out_ready = 1'b1;
        drive_beat(1'b1, 32'h0, 4'hF, 1'b0);
        tick();
        check("mk_restart_data", bus.out_data, 32'h7B777C63);

        // round trip: ciphertext under the same key yields the plaintext
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        load_key(8'h00);
        drive_beat(1'b1, 32'h6A554F27, 4'hF, 1'b0);
        tick();
        check("roundtrip_data", bus.out_data, 32'h11223344);
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        tick();

        // partial last beat
        load_key(8'h00);
        drive_beat(1'b1, 32'h00004241, 4'h3, 1'b1);
        tick();
        check("part_data", bus.out_data, 32'h00003E22);
        check("part_keep", {28'd0, bus.out_keep}, 32'h3);
        check("part_last", {31'd0, bus.out_last}, 32'd1);
        check("part_ctr", {24'd0, dbg_ctr}, 32'h02);
        check("part_busy", {31'd0, bus.busy}, 32'd0);
        check("part_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("part_after_valid", {31'd0, bus.out_valid}, 32'd0);
        check("part_after_ready", {31'd0, bus.in_ready}, 32'd0);

        // asynchronous reset mid-stream
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        load_key(8'h00);
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h0, 4'hF, 1'b0);
        tick();
        check("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ar_out_data", bus.out_data, 32'h0);
        check("ar_busy", {31'd0, bus.busy}, 32'd0);
        check("ar_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("ar_no_accept", {31'd0, bus.out_valid}, 32'd0);
        check("ar_ready_low", {31'd0, bus.in_ready}, 32'd0);
        load_key(8'h00);
        tick();
        check("ar_resume_data", bus.out_data, 32'h7B777C63);
        drive_beat(1'b0, 32'h0, 4'hF, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
